edge_window_ctrl: RTL and testbench

//  Raster-stream controller for the combinational 3x3 Sobel edge unit (edgeUnit).
//  - Buffers two video lines and builds the 3x3 window, then drives edgeUnit windowIn/threshold.
//  - Registers edgeUnit's edgePixel and emits one result per interior pixel: (H-2)x(W-2) per frame.
//  - Frame-level sequencing: start, abort, done.

---
 rtl/edge_ctrl_pkg.sv | 45 ++++
 rtl/edge_line_buf.sv | 43 ++++
 rtl/edge_window_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_edge_window_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_ctrl_pkg.sv
// edge_ctrl_pkg
//   Shared types and constants for the 3x3 window controller (edge_window_ctrl)
//   and its line buffers.
//   - state_t     : frame sequencer states
//   - WIN_*       : window geometry and slot numbering (slot = row*3 + col)
//   - win_w()     : packed window width for a given pixel width
//   - cnt_w()     : address / counter width for a given depth
//   The optional statistics counter is enabled by defining EDGE_CTRL_STATS_EN.
package edge_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int WIN_ROWS  = 3;
  localparam int WIN_COLS  = 3;
  localparam int WIN_SLOTS = WIN_ROWS * WIN_COLS;

  // Slot numbering: 0 = top-left .. 8 = bottom-right
  localparam int SLOT_TL = 0;
  localparam int SLOT_TC = 1;
  localparam int SLOT_TR = 2;
  localparam int SLOT_ML = 3;
  localparam int SLOT_MC = 4;
  localparam int SLOT_MR = 5;
  localparam int SLOT_BL = 6;
  localparam int SLOT_BC = 7;
  localparam int SLOT_BR = 8;

  function automatic int win_w(input int pix_w);
    return WIN_SLOTS * pix_w;
  endfunction

  function automatic int slot_idx(input int row, input int col);
    return row * WIN_COLS + col;
  endfunction

  // Index width for 0..depth-1 (never below 1 bit)
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/edge_line_buf.sv
// edge_line_buf
//   One video line of storage, inferred as block RAM. Registered read that
//   returns the contents before any write issued in the same cycle.
//   Ports:
//     clk        in  clock
//     rst_n      in  async active-low reset (read register only; RAM is don't-care)
//     en_i       in  access enable: write and read both happen only when set
//     wr_addr_i  in  write column
//     rd_addr_i  in  read column
//     wr_data_i  in  write data
//     rd_data_o  out registered read data, holds while en_i is low
//   The delayed (row r-2) buffer writes one beat behind its read column, so the
//   two addresses are separate ports; the row r-1 buffer ties them together.
module edge_line_buf
  import edge_ctrl_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [cnt_w(DEPTH)-1:0] wr_addr_i,
  input  logic [cnt_w(DEPTH)-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  output logic [WIDTH-1:0]        rd_data_o
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en_i) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rd_q <= '0;
    else if (en_i) rd_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/edge_window_ctrl.sv
// edge_window_ctrl
//   Raster-stream controller for a combinational 3x3 Sobel edge unit. Buffers
//   two lines, builds the 3x3 window, latches the frame threshold and registers
//   the edge unit's result: one output per interior pixel, latency 2 beats.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     pix_in / pix_valid    raster pixel stream, no backpressure
//     sof                   marks the (0,0) beat; in FILL/RUN it aborts and restarts
//     cfg_threshold         sampled on the accepted sof beat
//     win_out / thr_out     window and threshold to the edge unit
//     edge_in               edge unit result (combinational from win_out/thr_out)
//     out_pixel/out_valid   registered result strobe
//     out_last              with out_valid on the final interior pixel
//     frame_done            one-cycle pulse after out_last
//     busy                  high in FILL/RUN
//     edge_count/_vld       (EDGE_CTRL_STATS_EN only) non-zero result count per frame
module edge_window_ctrl
  import edge_ctrl_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIX_W-1:0]           pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  input  logic [PIX_W-1:0]           cfg_threshold,
  output logic [WIN_SLOTS*PIX_W-1:0] win_out,
  output logic [PIX_W-1:0]           thr_out,
  input  logic [PIX_W-1:0]           edge_in,
  output logic [PIX_W-1:0]           out_pixel,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       frame_done,
`ifdef EDGE_CTRL_STATS_EN
  output logic [CNT_W-1:0]           edge_count,
  output logic                       edge_count_vld,
`endif
  output logic                       busy
);

  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  if (CNT_W < $clog2((IMG_WIDTH - 2) * (IMG_HEIGHT - 2) + 1)) begin : g_cnt_w_too_small
    $error("CNT_W cannot hold the interior pixel count");
  end

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, cur_col, prev_col_q;
  logic [ROW_W-1:0]  row_q, row_d, cur_row;
  logic              start, take, last_beat, interior;
  logic [PIX_W-1:0]  thr_q;
  logic              win_vld_q, win_last_q;
  logic [PIX_W-1:0]  out_pixel_q;
  logic              out_valid_q, out_last_q, frame_done_q;
  logic [PIX_W-1:0]  lb_a_rd, lb_b_rd, pix_q;
  logic [PIX_W-1:0]  col0_q [WIN_ROWS];
  logic [PIX_W-1:0]  col1_q [WIN_ROWS];
  logic [PIX_W-1:0]  col2   [WIN_ROWS];

  // An sof beat is taken in any state and is always (0,0) of a fresh frame
  assign start   = pix_valid & sof;
  assign take    = pix_valid & (sof | (state_q != IDLE));
  assign cur_col = start ? '0 : col_q;
  assign cur_row = start ? '0 : row_q;

  assign last_beat = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign interior  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (take) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: if (take && cur_row == ROW_W'(1) && cur_col == COL_LAST) state_d = RUN;
      RUN: begin
        if (start)                  state_d = FILL;
        else if (take && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      prev_col_q   <= '0;
      thr_q        <= '0;
      win_vld_q    <= 1'b0;
      win_last_q   <= 1'b0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      if (take)  prev_col_q <= cur_col;
      if (start) thr_q      <= cfg_threshold;
      win_vld_q    <= take & interior;
      // Only a frame that actually reached its final pixel in RUN gets out_last
      win_last_q   <= take & last_beat & (state_q == RUN) & ~start;
      if (win_vld_q) out_pixel_q <= edge_in;
      out_valid_q  <= win_vld_q;
      out_last_q   <= win_last_q;
      frame_done_q <= out_last_q;
    end
  end

  // lb_a: row r-1, read-old/write-new at the current column.
  edge_line_buf #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (take),
    .wr_addr_i (cur_col),
    .rd_addr_i (cur_col),
    .wr_data_i (pix_in),
    .rd_data_o (lb_a_rd)
  );

  // lb_b: row r-2. The old lb_a word only appears on lb_a_rd one beat later,
  // so it is written back to the previous column on the next accepted beat;
  // that column is always read again no earlier than one line later.
  edge_line_buf #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (take),
    .wr_addr_i (prev_col_q),
    .rd_addr_i (cur_col),
    .wr_data_i (lb_a_rd),
    .rd_data_o (lb_b_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pix_q <= '0;
    else if (take) pix_q <= pix_in;
  end

  // The newest window column is the line-buffer read registers plus pix_q,
  // so the two older columns shift from it on the same accepted beat.
  assign col2[0] = lb_b_rd;
  assign col2[1] = lb_a_rd;
  assign col2[2] = pix_q;

  for (genvar gi = 0; gi < WIN_ROWS; gi++) begin : g_win_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        col0_q[gi] <= '0;
        col1_q[gi] <= '0;
      end else if (take) begin
        col0_q[gi] <= col1_q[gi];
        col1_q[gi] <= col2[gi];
      end
    end
    assign win_out[slot_idx(gi, 0)*PIX_W +: PIX_W] = col0_q[gi];
    assign win_out[slot_idx(gi, 1)*PIX_W +: PIX_W] = col1_q[gi];
    assign win_out[slot_idx(gi, 2)*PIX_W +: PIX_W] = col2[gi];
  end

  assign thr_out    = thr_q;
  assign out_pixel  = out_pixel_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

`ifdef EDGE_CTRL_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, frame_tot_q, edge_count_q;
  logic             edge_count_vld_q, hit;

  // Counted at the window stage so a back-to-back sof cannot clip the tail
  // of the previous frame; the total is captured with the frame's last window.
  assign hit = win_vld_q && (edge_in != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q        <= '0;
      frame_tot_q      <= '0;
      edge_count_q     <= '0;
      edge_count_vld_q <= 1'b0;
    end else begin
      if (start)    hit_cnt_q <= '0;
      else if (hit) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (win_last_q) frame_tot_q <= hit_cnt_q + CNT_W'(hit);
      edge_count_vld_q <= out_last_q;
      if (out_last_q) edge_count_q <= frame_tot_q;
      else if (start) edge_count_q <= '0;
    end
  end

  assign edge_count     = edge_count_q;
  assign edge_count_vld = edge_count_vld_q;
`endif

endmodule

// File: tb/tb_edge_window_ctrl.sv
module tb_edge_window_ctrl;

  localparam int PW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CW = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PW-1:0]   pix_in = '0;
  logic            pix_valid = 1'b0;
  logic            sof = 1'b0;
  logic [PW-1:0]   cfg_threshold = '0;
  logic [9*PW-1:0] win_out;
  logic [PW-1:0]   thr_out;
  logic [PW-1:0]   edge_in;
  logic [PW-1:0]   out_pixel;
  logic            out_valid, out_last, frame_done, busy;
`ifdef EDGE_CTRL_STATS_EN
  logic [CW-1:0]   edge_count;
  logic            edge_count_vld;
`endif

  edge_window_ctrl #(.PIX_W(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_in        (pix_in),
    .pix_valid     (pix_valid),
    .sof           (sof),
    .cfg_threshold (cfg_threshold),
    .win_out       (win_out),
    .thr_out       (thr_out),
    .edge_in       (edge_in),
    .out_pixel     (out_pixel),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .frame_done    (frame_done),
`ifdef EDGE_CTRL_STATS_EN
    .edge_count    (edge_count),
    .edge_count_vld(edge_count_vld),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Sobel edge unit: |Gx|+|Gy| above threshold gives 0xFF, else 0x00
  function automatic logic [PW-1:0] sobel(input logic [9*PW-1:0] w, input logic [PW-1:0] t);
    int p [9];
    int gx, gy, mag;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*PW +: PW]);
    gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > int'(t)) ? 8'hFF : 8'h00;
  endfunction

  always_comb edge_in = sobel(win_out, thr_out);

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  int n_out = 0;
  int fd_cnt = 0;
  int last_out_cyc = -10;
  int n_ecv = 0;
  logic [CW-1:0] last_ec = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_latency", cyc, e.cyc);
          check("out_pixel", out_pixel, e.val);
          check("out_last", out_last, e.last);
          n_out++;
          if (out_last) last_out_cyc = cyc;
        end
      end else if (out_last) begin
        check("out_last_without_valid", 1, 0);
      end
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_after_last", cyc, last_out_cyc + 1);
      end
`ifdef EDGE_CTRL_STATS_EN
      if (edge_count_vld) begin
        n_ecv++;
        last_ec = edge_count;
        check("ec_vld_with_frame_done", frame_done, 1);
      end
`endif
    end
  end

  // mode 0: pix = col*10, mode 1: constant 50
  task automatic send_frame(input int mode, input int gap, input int n_beats,
                            input logic [7:0] thr, input logic [7:0] expv, input bit thr_poke);
    for (int idx = 0; idx < n_beats; idx++) begin
      int r, c;
      exp_t e;
      r = idx / W;
      c = idx % W;
      pix_valid = 1'b1;
      sof       = (idx == 0);
      pix_in    = (mode == 0) ? 8'(c * 10) : 8'd50;
      if (idx == 0) cfg_threshold = thr;
      if (thr_poke && idx == 8) cfg_threshold = 8'd255;
      if (r >= 2 && c >= 2) begin
        e.cyc  = cyc + 2;
        e.val  = expv;
        e.last = (idx == W*H - 1);
        exp_q.push_back(e);
      end
      if (idx == 12) check("busy_mid_frame", busy, 1);
      @(posedge clk); #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_cnt < target && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done_count", fd_cnt, target);
    check("expect_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*PW-1:0] exp_win;
    int base;

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_win_out", win_out, 0);
    check("rst_thr_out", thr_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, threshold 30: six 0xFF results
    base = n_out;
    send_frame(0, 0, W*H, 8'd30, 8'hFF, 0);
    wait_fd(1);
    check("ramp_n_out", n_out - base, 6);
    check("ramp_busy_after", busy, 0);
    check("ramp_thr_out", thr_out, 30);
    // Window holds the one centred on (2,3): columns 2,3,4 in every row
    for (int i = 0; i < 9; i++) exp_win[i*PW +: PW] = 8'((2 + i % 3) * 10);
    check("ramp_win_hold", win_out, exp_win);
`ifdef EDGE_CTRL_STATS_EN
    check("stats_ramp_vld_cnt", n_ecv, 1);
    check("stats_ramp_count", last_ec, 6);
`endif

    // Constant frame, threshold 0: six 0x00 results
    base = n_out;
    send_frame(1, 0, W*H, 8'd0, 8'h00, 0);
    wait_fd(2);
    check("const_n_out", n_out - base, 6);
    check("const_busy_after", busy, 0);
`ifdef EDGE_CTRL_STATS_EN
    check("stats_const_vld_cnt", n_ecv, 2);
    check("stats_const_count", last_ec, 0);
`endif

    // Ramp frame with gaps and a mid-frame threshold change
    base = n_out;
    send_frame(0, 1, W*H, 8'd30, 8'hFF, 1);
    wait_fd(3);
    check("gap_n_out", n_out - base, 6);
    check("gap_thr_stable", thr_out, 30);

    // Abort after 7 pixels, then a full ramp frame
    base = n_out;
    send_frame(1, 0, 7, 8'd0, 8'h00, 0);
    send_frame(0, 0, W*H, 8'd30, 8'hFF, 0);
    wait_fd(4);
    repeat (5) @(posedge clk);
    #1;
    check("abort_single_frame_done", fd_cnt, 4);
    check("abort_n_out", n_out - base, 6);

    // Reset mid-RUN with a result in flight
    base = n_out;
    send_frame(0, 0, 13, 8'd30, 8'hFF, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pixel", out_pixel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_win_out", win_out, 0);
    check("midrst_thr_out", thr_out, 0);
    check("midrst_frame_done", frame_done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(i * 7);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_output", n_out - base, 0);
    check("midrst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
